// File: rtl/cnt_pkg.sv
// Shared constants for the mod-14 counter controller: state encoding, error codes
// and the expected stop-count helper.
package cnt_pkg;

    localparam int unsigned MOD = 14;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_START = 3'd1;
    localparam state_t S_RUN   = 3'd2;
    localparam state_t S_STOP  = 3'd3;
    localparam state_t S_ACK   = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TGT  = 2'd1;
    localparam logic [1:0] ERR_RUN  = 2'd2;
    localparam logic [1:0] ERR_ACK  = 2'd3;

    // Stop is seen one increment late and the counter steps again on the stop edge.
    function automatic logic [3:0] expect_stop_count(input logic [3:0] tgt);
        logic [3:0] s;
        s = tgt + 4'd2;
        return (s >= 4'(MOD)) ? s - 4'(MOD) : s;
    endfunction

endpackage

// File: rtl/cnt_timer.sv
// Loadable down-counter with a zero flag, shared by the RUN and ACK timeouts.
module cnt_timer
    import cnt_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cnt_ctrl.sv
// Command-driven start/stop controller for a companion mod-14 counter, with
// run/ack timeouts and a check of the captured stop count.
module cnt_ctrl
    import cnt_pkg::*;
#(
    parameter int unsigned RUN_TMO = 16,
    parameter int unsigned ACK_TMO = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_target,
    input  logic [3:0] count_in,
    input  logic       stop_d2_in,
    output logic       start,
    output logic       stop,
    output logic       done,
    output logic [3:0] done_count,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned TMAX = (RUN_TMO > ACK_TMO) ? RUN_TMO : ACK_TMO;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_t     state_q, state_d;
    logic [3:0] tgt_q, tgt_d;
    logic [1:0] pend_q, pend_d;
    logic [3:0] done_count_q, done_count_d;
    logic       err_d;
    logic [1:0] err_code_d;
    logic       start_q, stop_q, done_q, err_q;
    logic [1:0] err_code_q;

    logic          tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] tmr_load_val;

    cnt_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        pend_d       = pend_q;
        done_count_d = done_count_q;
        err_d        = 1'b0;
        err_code_d   = ERR_NONE;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            S_IDLE: begin
                pend_d = ERR_NONE;
                if (cmd_valid) begin
                    if (cmd_target <= 4'(MOD - 1)) begin
                        tgt_d   = cmd_target;
                        state_d = S_START;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TGT;
                    end
                end
            end
            S_START: begin
                // Loaded with N-1 so the state lasts exactly N cycles before zero ends it.
                tmr_load     = 1'b1;
                tmr_load_val = TW'(RUN_TMO - 1);
                state_d      = S_RUN;
            end
            S_RUN: begin
                if (count_in == tgt_q) begin
                    state_d = S_STOP;
                end else if (tmr_zero) begin
                    state_d = S_STOP;
                    pend_d  = ERR_RUN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_STOP: begin
                tmr_load     = 1'b1;
                tmr_load_val = TW'(ACK_TMO - 1);
                state_d      = S_ACK;
            end
            S_ACK: begin
                if (stop_d2_in) begin
                    done_count_d = count_in;
                    state_d      = S_DONE;
                    if ((pend_q == ERR_NONE) && (count_in != expect_stop_count(tgt_q))) begin
                        pend_d = ERR_ACK;
                    end
                end else if (tmr_zero) begin
                    state_d = S_DONE;
                    if (pend_q == ERR_NONE) begin
                        pend_d = ERR_ACK;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            err_d      = (pend_d != ERR_NONE);
            err_code_d = pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tgt_q        <= '0;
            pend_q       <= ERR_NONE;
            done_count_q <= '0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            pend_q       <= pend_d;
            done_count_q <= done_count_d;
            start_q      <= (state_d == S_START);
            stop_q       <= (state_d == S_STOP);
            done_q       <= (state_d == S_DONE);
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign start      = start_q;
    assign stop       = stop_q;
    assign done       = done_q;
    assign done_count = done_count_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Scoreboard bench for cnt_ctrl with a looped-back mod-14 counter model.
module tb_cnt_ctrl;

    typedef struct {
        logic       done;
        logic [3:0] dc;
        logic       err;
        logic [1:0] ec;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_target = 4'd0;
    logic [3:0] count_in;
    logic       stop_d2_in;
    logic       start, stop, done, err;
    logic [3:0] done_count;
    logic [1:0] err_code;

    logic       cnt_hold = 1'b0;
    logic       d2_kill  = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic       run = 1'b0;
    logic       stop_d1 = 1'b0, stop_d2 = 1'b0;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_start = 0, n_stop = 0;
    int t_start = 0, t_stop = 0, t_done = 0;
    int stop_cnt = 0;
    bit both_seen = 1'b0;
    resp_t sb[$];
    resp_t mon_e;

    cnt_ctrl #(.RUN_TMO(16), .ACK_TMO(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .count_in   (count_in),
        .stop_d2_in (stop_d2_in),
        .start      (start),
        .stop       (stop),
        .done       (done),
        .done_count (done_count),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Companion counter: steps while running, including on the stop edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || cnt_hold) begin
            cnt <= 4'd0;
            run <= 1'b0;
        end else begin
            if (run) cnt <= (cnt == 4'd13) ? 4'd0 : cnt + 4'd1;
            if (start) run <= 1'b1;
            else if (stop) run <= 1'b0;
        end
        stop_d1 <= rst ? 1'b0 : stop;
        stop_d2 <= rst ? 1'b0 : stop_d1;
    end

    assign count_in   = cnt;
    assign stop_d2_in = d2_kill ? 1'b0 : stop_d2;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Monitor: pops the scoreboard whenever done or err is presented.
    always @(negedge clk) begin
        if (start) begin n_start++; t_start = cyc; end
        if (stop)  begin n_stop++;  t_stop = cyc; stop_cnt = int'(count_in); end
        if (start && stop) both_seen = 1'b1;
        if (done) t_done = cyc;
        if (done || err) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_resp: done=%0d err=%0d code=%0d count=%0d",
                         done, err, err_code, done_count);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_done", int'(done), int'(mon_e.done));
                chk("resp_done_count", int'(done_count), int'(mon_e.dc));
                chk("resp_err", int'(err), int'(mon_e.err));
                chk("resp_err_code", int'(err_code), int'(mon_e.ec));
            end
        end
    end

    task automatic issue(input logic [3:0] tgt, input bit push, input resp_t e);
        int k;
        k = 0;
        while (!cmd_ready && k < 60) begin @(negedge clk); k++; end
        if (!cmd_ready) begin
            tmo("cmd_ready_wait");
        end else begin
            if (push) sb.push_back(e);
            cmd_valid  = 1'b1;
            cmd_target = tgt;
            @(negedge clk);
            cmd_valid  = 1'b0;
        end
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin @(negedge clk); k++; end
        if (sb.size() != 0) tmo(nm);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s0, p0;
        resp_t e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_start", int'(start), 0);
        chk("rst_stop", int'(stop), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_done_count", int'(done_count), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);

        // target 5 from count 0; busy-time cmd_valid must be ignored
        s0 = n_start; p0 = n_stop;
        e = '{done: 1'b1, dc: 4'd7, err: 1'b0, ec: 2'd0};
        issue(4'd5, 1'b1, e);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1; cmd_target = 4'd1;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done("t5_done");
        chk("t5_start_pulses", n_start - s0, 1);
        chk("t5_stop_pulses", n_stop - p0, 1);
        chk("t5_stop_count", stop_cnt, 6);
        chk("t5_start_to_stop", t_stop - t_start, 7);

        // target 12 wraps, then target 3 resumes from 0
        do_reset();
        e = '{done: 1'b1, dc: 4'd0, err: 1'b0, ec: 2'd0};
        issue(4'd12, 1'b1, e);
        wait_done("t12_done");
        e = '{done: 1'b1, dc: 4'd5, err: 1'b0, ec: 2'd0};
        issue(4'd3, 1'b1, e);
        wait_done("t3_done");
        chk("t3_stop_count", stop_cnt, 4);

        // illegal target
        s0 = n_start;
        e = '{done: 1'b0, dc: 4'd5, err: 1'b1, ec: 2'd1};
        issue(4'd14, 1'b1, e);
        chk("t14_cmd_ready", int'(cmd_ready), 1);
        wait_done("t14_err");
        chk("t14_start_pulses", n_start - s0, 0);
        chk("t14_cmd_ready_after", int'(cmd_ready), 1);

        // counter stuck at 0 -> run timeout
        cnt_hold = 1'b1;
        e = '{done: 1'b1, dc: 4'd0, err: 1'b1, ec: 2'd2};
        issue(4'd4, 1'b1, e);
        wait_done("run_tmo_done");
        chk("run_tmo_start_to_stop", t_stop - t_start, 17);
        cnt_hold = 1'b0;

        // normal target 1, then ack timeout keeps done_count
        e = '{done: 1'b1, dc: 4'd3, err: 1'b0, ec: 2'd0};
        issue(4'd1, 1'b1, e);
        wait_done("t1_done");
        d2_kill = 1'b1;
        e = '{done: 1'b1, dc: 4'd3, err: 1'b1, ec: 2'd3};
        issue(4'd2, 1'b1, e);
        wait_done("ack_tmo_done");
        chk("ack_tmo_stop_to_done", t_done - t_stop, 5);
        d2_kill = 1'b0;

        // reset during RUN aborts without a stop pulse
        p0 = n_stop;
        e = '{done: 1'b0, dc: 4'd0, err: 1'b0, ec: 2'd0};
        issue(4'd10, 1'b0, e);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_stop", int'(stop), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready_after", int'(cmd_ready), 1);
        repeat (25) @(negedge clk);
        chk("abort_stop_pulses", n_stop - p0, 0);

        chk("start_stop_overlap", int'(both_seen), 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cnt_ctrl.md
CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 SHALL have parameter RUN_TMO, default 16, meaning max cycles in RUN without target match before a forced stop.
REQ-002 SHALL have parameter ACK_TMO, default 4, meaning max cycles in ACK waiting for stop_d2_in.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-007 cmd_target  input  4  count value at which stop is issued, legal range 0..13.
REQ-008 count_in  input  4  current value of the mod-14 counter.
REQ-009 stop_d2_in  input  1  stop echo from the counter, delayed two cycles.
REQ-010 start  output  1  registered one-cycle start pulse to the counter.
REQ-011 stop  output  1  registered one-cycle stop pulse to the counter.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 done_count  output  4  count_in captured at ack; holds until the next done.
REQ-014 err  output  1  one-cycle pulse with done, or alone on illegal command.
REQ-015 err_code  output  2  0 none, 1 illegal target, 2 run timeout, 3 ack timeout or result mismatch; valid with err.

Function
REQ-016 The FSM SHALL have states IDLE, START, RUN, STOP, ACK, DONE.
REQ-017 IDLE: on accept with target <= 13, latch target and go to START; with target > 13, stay in IDLE and pulse err with err_code=1 the next cycle.
REQ-018 START: drive start=1 for exactly one cycle, then go to RUN.
REQ-019 RUN: when count_in == latched target, go to STOP; after RUN_TMO cycles without a match, go to STOP with a pending err_code=2.
REQ-020 STOP: drive stop=1 for exactly one cycle, then go to ACK.
REQ-021 ACK: in the first cycle with stop_d2_in=1, capture count_in into done_count and go to DONE; after ACK_TMO cycles without it, go to DONE with err_code=3 and done_count unchanged.
REQ-022 DONE: pulse done for one cycle and return to IDLE.
REQ-023 Result check: if no prior error, the captured value SHALL equal (target+2) mod 14, because stop is seen one increment late and the counter increments again on the stop edge. On a mismatch, pulse err with err_code=3 alongside done.
REQ-024 The target+2 arithmetic SHALL wrap modulo 14 (12->0, 13->1) using 4-bit unsigned arithmetic.
REQ-025 start and stop SHALL never be high in the same cycle. Neither SHALL be high outside START or STOP respectively.
REQ-026 cmd_valid SHALL be ignored outside IDLE, with no queueing.
REQ-027 A stop_d2_in pulse outside ACK SHALL be ignored.

Reset
REQ-028 With rst high at a clock edge: state=IDLE, start=0, stop=0, done=0, err=0, err_code=0, done_count=0, timers=0, latched target=0.
REQ-029 Reset SHALL abort any operation mid-flight without issuing a stop pulse. The cycle after reset release, cmd_ready=1.

Structure
REQ-030 State encoding, err_code values and constant MOD=14 SHALL live in shared package cnt_pkg.
REQ-031 The RUN and ACK timeout SHALL share one sub-module cnt_timer: a loadable down-counter with a zero flag.
REQ-032 No other sub-modules. The companion mod-14 counter is instantiated only in the bench.

Verification (bench connects the companion counter, start/stop and stop_d2 looped back)
REQ-033 From reset (count 0), cmd_target=5 -> one start pulse; stop high while count_in=6; stop_d2_in 2 cycles later; done with done_count=7, err=0.
REQ-034 cmd_target=12 from count 0 -> done_count=0 (wrap), err=0. A second command, target 3 -> counting resumes from 0, done_count=5.
REQ-035 cmd_target=14 -> no start pulse; err=1 with err_code=1; cmd_ready stays 1.
REQ-036 Counter held in reset (count stuck at 0), target 4 -> stop after 16 RUN cycles; done with err_code=2.
REQ-037 stop_d2_in tied 0 -> done after 4 ACK cycles with err_code=3; done_count unchanged. rst asserted in RUN -> IDLE next cycle, no stop pulse.
